uart2ahb_fifo: RTL and testbench
================================

# uart2ahb_fifo

- AHB-Lite slave UART, successor to the plain UART-over-AHB top.
- Adds parametrised TX/RX FIFOs, a memory-mapped register map with run-time baud divisor, sticky error flags and zero-wait-state access.
- Sits on the system AHB bus as a peripheral; drives `txd` and samples `rxd`.

## Interface
Parameters:
- DATA_WIDTH, 32, AHB data width (≥32)
- ADDR_WIDTH, 32, AHB address width
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, ≥2
- BAUD_DIV_RST, 16'd867, reset value of BAUD register

Ports:
- hclk  in  1  clock
- hrst_n  in  1  asynchronous active-low reset
- m_haddr_i  in  ADDR_WIDTH  address; only [3:2] decoded
- m_htrans_i  in  2  transfer type
- m_hwrite_i  in  1  1 = write
- m_hsize_i  in  3  ignored
- m_hwdata_i  in  DATA_WIDTH  write data (data phase)
- m_hsel_i  in  1  slave select
- s_hrdata_o  out  DATA_WIDTH  read data
- s_hready_o  out  1  constant 1
- s_resp_o  out  2  constant 2'b00 (OKAY)
- rxd  in  1  serial in, asynchronous
- txd  out  1  serial out, idle high
- tx_busy  out  1  transmitter framing a character
- rx_busy  out  1  receiver inside a frame
- rx_overrun_error  out  1  sticky, mirrors STATUS[6]
- rx_frame_error  out  1  sticky, mirrors STATUS[7]

## Operation
- Transfer accepted when m_hsel_i & m_htrans_i[1]. Address phase registers addr[3:2], write, valid. Action takes place in the following data-phase cycle.
- Register map:
  - 0x0 DATA
    - Write pushes hwdata[7:0] to the TX FIFO. If full: dropped, no flag.
    - Read returns the RX head in [7:0] and pops it. If empty: returns 0, no pop.
  - 0x4 STATUS (read)
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_busy, [5] rx_busy
    - [6] overrun, [7] frame_err, [8] parity_err
    - [31:16] rx_count
  - 0x4 STATUS (write): write 1 to clear bits [8:6].
  - 0x8 BAUD: [15:0] divisor, R/W. Bit period = max(div,3)+1 hclk cycles.
  - 0xC: reads 0, writes ignored.
- FIFOs: circular, pointers one bit wider than log2(FIFO_DEPTH); full/empty derived from the pointers.
- TX FSM:
  - States IDLE, START, DATA(8, LSB first), [PARITY], STOP.
  - IDLE with TX FIFO non-empty: pop, go to START.
  - Leaving STOP with FIFO non-empty: go directly to START, giving back-to-back frames with no idle gap.
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - IDLE: a falling edge moves to START.
  - START: wait (div+1)/2 cycles, then sample. A high sample is a false start; return to IDLE with no flag.
  - DATA bits, then [PARITY], then STOP are each sampled one bit period apart.
  - At the STOP sample:
    - stop=0: set frame_err, discard the byte.
    - FIFO full with no same-cycle pop: set overrun, discard the byte.
    - otherwise: push the byte.
  - Return to IDLE immediately after the STOP sample, half a bit early, to resynchronise.
- Simultaneous events:
  - RX push and AHB pop in the same cycle on a full FIFO: both succeed.
  - Sticky-flag set and W1C in the same cycle: set wins.
- BAUD write mid-frame: the new value is loaded at the next bit-period boundary.

## Timing
- Reset values: txd=1; tx_busy, rx_busy, error flags = 0; FIFOs empty; BAUD = BAUD_DIV_RST; s_hrdata_o = 0.
- s_hrdata_o is combinational in a read data phase and 0 otherwise.
- Zero wait states: every transfer completes in its data-phase cycle.
- TX latency: a DATA write to idle TX with an empty FIFO drives txd low (start bit) 1 cycle after the write's data-phase cycle.
- tx_busy is high from the start of the start bit to the end of the stop bit.
- Frame length is 10 bits, or 11 with parity.
- RX latency: the byte is visible in the FIFO (rx_empty=0) the cycle after the stop sample.
- Sampling happens 2 cycles after the line edge because of the synchroniser.
- Reset mid-frame: txd returns high immediately and the partial RX frame is discarded.

## Configuration
- UART2AHB_PARITY_EN defined:
  - Even parity bit inserted after D7 on TX and checked on RX.
  - A mismatch sets STATUS[8]; the byte is still pushed if the stop bit is valid.
  - Frame is 11 bits.
- Undefined:
  - No parity state; frame is 10 bits.
  - STATUS[8] reads 0.

## Test plan
- Reset, read STATUS → 0x0000_000A (tx_empty, rx_empty); read BAUD → 0x363; txd=1.
- BAUD=3, write DATA=0xA5 → txd emits 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles, 40 cycles total; tx_busy high throughout; STATUS[1]=1 afterwards.
- BAUD=3, drive rxd frame 0x3C → rx_count=1; DATA read returns 0x3C, then STATUS[3]=1.
- Fill RX with FIFO_DEPTH frames, then send one more → STATUS[6]=1, rx_overrun_error=1; write STATUS=0x40 → cleared.
- rxd frame with stop bit 0 → rx_frame_error=1, rx_count unchanged; 2-cycle low glitch on rxd → no flag, rx_busy returns to 0.
- Write FIFO_DEPTH+2 bytes back-to-back → first FIFO_DEPTH+1 transmitted, with no idle between frames (one popped immediately into the shifter); last byte dropped.

Source files
------------

// File: rtl/uart2ahb_fifo.sv
// AHB-Lite UART with TX/RX FIFOs, run-time baud divisor and sticky error flags.
// Define UART2AHB_PARITY_EN to add an even parity bit after D7 in both directions.

module uart2ahb_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     hclk,
  input  logic                     hrst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign push_ok = push & (~full | pop_ok);
  assign count   = wr_ptr - rd_ptr;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge hclk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

module uart2ahb_fifo #(
  parameter int          DATA_WIDTH   = 32,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] BAUD_DIV_RST = 16'd867
) (
  input  logic                  hclk,
  input  logic                  hrst_n,
  input  logic [ADDR_WIDTH-1:0] m_haddr_i,
  input  logic [1:0]            m_htrans_i,
  input  logic                  m_hwrite_i,
  input  logic [2:0]            m_hsize_i,
  input  logic [DATA_WIDTH-1:0] m_hwdata_i,
  input  logic                  m_hsel_i,
  output logic [DATA_WIDTH-1:0] s_hrdata_o,
  output logic                  s_hready_o,
  output logic [1:0]            s_resp_o,
  input  logic                  rxd,
  output logic                  txd,
  output logic                  tx_busy,
  output logic                  rx_busy,
  output logic                  rx_overrun_error,
  output logic                  rx_frame_error
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef UART2AHB_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef UART2AHB_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  // AHB address phase capture
  logic [1:0]  addr_q;
  logic        write_q, valid_q;
  logic        wr_en, rd_en;
  logic [15:0] baud_q, eff_div;
  logic [2:0]  clr;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= m_haddr_i[3:2];
      write_q <= m_hwrite_i;
      valid_q <= m_hsel_i & m_htrans_i[1];
    end
  end

  assign wr_en   = valid_q & write_q;
  assign rd_en   = valid_q & ~write_q;
  assign clr     = (wr_en && addr_q == 2'd1) ? m_hwdata_i[8:6] : 3'b000;
  assign eff_div = (baud_q < 16'd3) ? 16'd3 : baud_q;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n)                       baud_q <= BAUD_DIV_RST;
    else if (wr_en && addr_q == 2'd2)  baud_q <= m_hwdata_i[15:0];
  end

  // FIFOs
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout, rx_sh_q;
  logic [CW-1:0] rx_count;

  assign tx_push = wr_en && addr_q == 2'd0 && !tx_full;
  assign rx_pop  = rd_en && addr_q == 2'd0 && !rx_empty;

  uart2ahb_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .hclk(hclk), .hrst_n(hrst_n), .push(tx_push), .din(m_hwdata_i[7:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart2ahb_fifo_buf #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .hclk(hclk), .hrst_n(hrst_n), .push(rx_push), .din(rx_sh_q),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Transmitter: counters hold "cycles left in this bit minus one"
  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_par_q;

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_par_q <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      if (tx_pop) tx_par_q <= ^tx_dout;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    tx_next  = tx_state;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    case (tx_state)
      TX_IDLE:  tx_pop = !tx_empty;
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = eff_div;
          tx_bit_d = '0;
          tx_next  = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = eff_div;
          tx_sh_d  = tx_sh_q >> 1;
          if (tx_bit_q == 3'd7) begin
`ifdef UART2AHB_PARITY_EN
            tx_next = TX_PARITY;
`else
            tx_next = TX_STOP;
`endif
          end else tx_bit_d = tx_bit_q + 3'd1;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
`ifdef UART2AHB_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = eff_div;
          tx_next  = TX_STOP;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
`endif
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_pop  = !tx_empty;
          tx_next = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_next = TX_IDLE;
    endcase
    // Popping straight out of STOP chains frames with no idle gap.
    if (tx_pop) begin
      tx_sh_d  = tx_dout;
      tx_cnt_d = eff_div;
      tx_next  = TX_START;
    end
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_sh_q[0];
`ifdef UART2AHB_PARITY_EN
      TX_PARITY: txd = tx_par_q;
`endif
      default:   txd = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // Receiver
  rx_state_t   rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_half;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_d;
  logic        set_ovr, set_fe, set_pe;
  logic        ovr_q, fe_q, pe_q;

  assign rx_half = {1'b0, eff_div[15:1]} + {15'b0, eff_div[0]};

  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      ovr_q    <= 1'b0;
      fe_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      // A new error in the same cycle as a clear wins.
      ovr_q    <= set_ovr | (ovr_q & ~clr[0]);
      fe_q     <= set_fe  | (fe_q  & ~clr[1]);
      pe_q     <= set_pe  | (pe_q  & ~clr[2]);
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    set_ovr  = 1'b0;
    set_fe   = 1'b0;
    set_pe   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_cnt_d = rx_half - 16'd1;
          rx_next  = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2) rx_next = RX_IDLE;
          else begin
            rx_cnt_d = eff_div;
            rx_bit_d = '0;
            rx_next  = RX_DATA;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d = eff_div;
          rx_sh_d  = {rx_s2, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART2AHB_PARITY_EN
            rx_next = RX_PARITY;
`else
            rx_next = RX_STOP;
`endif
          end else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
`ifdef UART2AHB_PARITY_EN
      RX_PARITY: begin
        if (rx_cnt_q == '0) begin
          set_pe   = (^rx_sh_q) ^ rx_s2;
          rx_cnt_d = eff_div;
          rx_next  = RX_STOP;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
`endif
      RX_STOP: begin
        // Back to IDLE mid stop bit so the next start edge is never missed.
        if (rx_cnt_q == '0) begin
          rx_next = RX_IDLE;
          if (!rx_s2)                set_fe  = 1'b1;
          else if (rx_full && !rx_pop) set_ovr = 1'b1;
          else                       rx_push = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  assign rx_busy          = (rx_state != RX_IDLE);
  assign rx_overrun_error = ovr_q;
  assign rx_frame_error   = fe_q;

  // Read mux
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    case (addr_q)
      2'd0: rd_word = rx_empty ? 32'd0 : {24'd0, rx_dout};
      2'd1: rd_word = {16'(rx_count), 7'd0, pe_q, fe_q, ovr_q, rx_busy, tx_busy,
                       rx_empty, rx_full, tx_empty, tx_full};
      2'd2: rd_word = {16'd0, baud_q};
      default: rd_word = '0;
    endcase
  end

  assign s_hrdata_o = rd_en ? DATA_WIDTH'(rd_word) : '0;
  assign s_hready_o = 1'b1;
  assign s_resp_o   = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{m_haddr_i[ADDR_WIDTH-1:4], m_haddr_i[1:0], m_htrans_i[0],
                         m_hsize_i, m_hwdata_i[DATA_WIDTH-1:16], tx_count};
endmodule

// File: tb/tb_uart2ahb_fifo.sv
// Self-checking bench for uart2ahb_fifo: directed sequence with random payloads
// checked against a queue-based model of the register map and serial framing.

module tb_uart2ahb_fifo;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int BITC  = 4;  // hclk cycles per bit with BAUD = 3
`ifdef UART2AHB_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic          hclk = 1'b0;
  logic          hrst_n;
  logic [AW-1:0] m_haddr_i;
  logic [1:0]    m_htrans_i;
  logic          m_hwrite_i;
  logic [2:0]    m_hsize_i;
  logic [DW-1:0] m_hwdata_i;
  logic          m_hsel_i;
  logic [DW-1:0] s_hrdata_o;
  logic          s_hready_o;
  logic [1:0]    s_resp_o;
  logic          rxd, txd, tx_busy, rx_busy, rx_overrun_error, rx_frame_error;

  uart2ahb_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .hclk(hclk), .hrst_n(hrst_n), .m_haddr_i(m_haddr_i), .m_htrans_i(m_htrans_i),
    .m_hwrite_i(m_hwrite_i), .m_hsize_i(m_hsize_i), .m_hwdata_i(m_hwdata_i),
    .m_hsel_i(m_hsel_i), .s_hrdata_o(s_hrdata_o), .s_hready_o(s_hready_o),
    .s_resp_o(s_resp_o), .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error)
  );

  always #5 hclk = ~hclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: RX FIFO contents and sticky flags
  byte unsigned rx_model[$];
  bit           m_ovr, m_fe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[31:16] = 16'(rx_model.size());
    s[7]     = m_fe;
    s[6]     = m_ovr;
    s[3]     = (rx_model.size() == 0);
    s[2]     = (rx_model.size() == DEPTH);
    s[1]     = 1'b1;
    return s;
  endfunction

  // Line levels of one character, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input byte unsigned b, input bit stop_ok);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART2AHB_PARITY_EN
    f[9]  = ^b;
    f[10] = stop_ok;
`else
    f[9]  = stop_ok;
`endif
    return f;
  endfunction

  task automatic idle_bus();
    m_hsel_i   = 1'b0;
    m_htrans_i = 2'b00;
    m_hwrite_i = 1'b0;
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    @(negedge hclk);
    m_hsel_i = 1'b1; m_htrans_i = 2'b10; m_hwrite_i = 1'b1; m_haddr_i = {28'd0, addr};
    @(negedge hclk);
    idle_bus();
    m_hwdata_i = data;
  endtask

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge hclk);
    m_hsel_i = 1'b1; m_htrans_i = 2'b10; m_hwrite_i = 1'b0; m_haddr_i = {28'd0, addr};
    @(negedge hclk);
    idle_bus();
    data = s_hrdata_o;
  endtask

  // Serial driver; the model is updated with what the receiver should conclude.
  task automatic send_rx(input byte unsigned b, input bit stop_ok);
    logic [10:0] f;
    f = frame_bits(b, stop_ok);
    for (int i = 0; i < FBITS; i++) begin
      rxd = f[i];
      repeat (BITC) @(negedge hclk);
    end
    rxd = 1'b1;
    repeat (2 * BITC) @(negedge hclk);
    if (!stop_ok)                   m_fe = 1'b1;
    else if (rx_model.size() == DEPTH) m_ovr = 1'b1;
    else                            rx_model.push_back(b);
  endtask

  // Waits for a start bit, then checks every cycle of the given frames back to back.
  task automatic tx_watch(input byte unsigned bytes[$], output int lat);
    logic [10:0] f;
    lat = 0;
    while (txd !== 1'b0 && lat < 300) begin
      @(negedge hclk);
      lat++;
    end
    check("tx_start_seen", 32'(lat < 300), 32'd1);
    foreach (bytes[k]) begin
      f = frame_bits(bytes[k], 1'b1);
      for (int i = 0; i < FBITS; i++)
        for (int c = 0; c < BITC; c++) begin
          check($sformatf("txd_b%0d_bit%0d", k, i), {31'd0, txd}, {31'd0, f[i]});
          check("tx_busy_frame", {31'd0, tx_busy}, 32'd1);
          @(negedge hclk);
        end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  rd;
    int           lat;
    byte unsigned q[$];
    byte unsigned b;

    hrst_n = 1'b0; rxd = 1'b1; m_haddr_i = '0; m_hwdata_i = '0; m_hsize_i = 3'b010;
    idle_bus();
    m_ovr = 1'b0; m_fe = 1'b0;
    repeat (3) @(negedge hclk);
    hrst_n = 1'b1;

    // Reset state
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
    check("rst_err", {30'd0, rx_overrun_error, rx_frame_error}, 32'd0);
    check("rst_hready_resp", {29'd0, s_hready_o, s_resp_o}, 32'd4);
    check("rst_hrdata", s_hrdata_o, 32'd0);
    ahb_read(4'h4, rd); check("rst_status", rd, 32'h0000_000A);
    ahb_read(4'h8, rd); check("rst_baud", rd, 32'h0000_0363);
    ahb_read(4'hC, rd); check("reg_c_zero", rd, 32'd0);

    // TX 0xA5 at BAUD=3 with first-bit latency check
    ahb_write(4'h8, 32'd3);
    ahb_read(4'h8, rd); check("baud_rb", rd, 32'd3);
    ahb_write(4'h0, 32'hA5);
    q = '{8'hA5};
    tx_watch(q, lat);
    check("tx_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
    check("tx_idle_after", {30'd0, txd, tx_busy}, 32'd2);
    ahb_read(4'h4, rd); check("status_after_tx", rd, exp_status());

    // Divisor below 3 is clamped: bit period stays 4 cycles
    ahb_write(4'h8, 32'd1);
    b = 8'($urandom);
    ahb_write(4'h0, {24'd0, b});
    q = '{b};
    tx_watch(q, lat);
    ahb_write(4'h8, 32'd3);

    // RX 0x3C then random bytes
    send_rx(8'h3C, 1'b1);
    ahb_read(4'h4, rd); check("status_rx1", rd, exp_status());
    ahb_read(4'h0, rd); check("rx_data_3c", rd, {24'd0, rx_model.pop_front()});
    ahb_read(4'h4, rd); check("status_rx_empty", rd, exp_status());
    ahb_read(4'h0, rd); check("rx_empty_read", rd, 32'd0);
    for (int i = 0; i < 3; i++) send_rx(8'($urandom), 1'b1);
    ahb_read(4'h4, rd); check("status_rx3", rd, exp_status());
    for (int i = 0; i < 3; i++) begin
      ahb_read(4'h0, rd); check("rx_data_rand", rd, {24'd0, rx_model.pop_front()});
    end

    // Fill, overrun, clear, drain
    for (int i = 0; i < DEPTH; i++) send_rx(8'($urandom), 1'b1);
    ahb_read(4'h4, rd); check("status_full", rd, exp_status());
    send_rx(8'($urandom), 1'b1);
    check("ovr_pin", {31'd0, rx_overrun_error}, {31'd0, m_ovr});
    ahb_read(4'h4, rd); check("status_ovr", rd, exp_status());
    ahb_write(4'h4, 32'h40);
    m_ovr = 1'b0;
    @(negedge hclk);
    check("ovr_pin_clr", {31'd0, rx_overrun_error}, 32'd0);
    ahb_read(4'h4, rd); check("status_ovr_clr", rd, exp_status());
    while (rx_model.size() > 0) begin
      ahb_read(4'h0, rd); check("rx_drain", rd, {24'd0, rx_model.pop_front()});
    end

    // Frame error, then glitch
    send_rx(8'($urandom), 1'b0);
    check("fe_pin", {31'd0, rx_frame_error}, 32'd1);
    ahb_read(4'h4, rd); check("status_fe", rd, exp_status());
    ahb_write(4'h4, 32'h80);
    m_fe = 1'b0;
    @(negedge hclk);
    rxd = 1'b0;
    repeat (2) @(negedge hclk);
    rxd = 1'b1;
    repeat (10) @(negedge hclk);
    check("glitch_rx_busy", {31'd0, rx_busy}, 32'd0);
    ahb_read(4'h4, rd); check("status_glitch", rd, exp_status());

    // DEPTH+2 back-to-back writes: DEPTH+1 frames with no gap, last byte dropped
    q = {};
    for (int i = 0; i < DEPTH + 2; i++) q.push_back(8'($urandom));
    fork
      begin
        @(negedge hclk);
        m_hsel_i = 1'b1; m_htrans_i = 2'b10; m_hwrite_i = 1'b1; m_haddr_i = '0;
        for (int i = 0; i < DEPTH + 2; i++) begin
          @(negedge hclk);
          m_hwdata_i = {24'd0, q[i]};
          if (i == DEPTH + 1) idle_bus();
        end
      end
      begin
        byte unsigned sent[$];
        sent = q[0:DEPTH];
        tx_watch(sent, lat);
      end
    join
    begin
      int lows = 0;
      for (int i = 0; i < 3 * FBITS * BITC; i++) begin
        if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
        @(negedge hclk);
      end
      check("tx_extra_frame", 32'(lows), 32'd0);
    end
    ahb_read(4'h4, rd); check("status_after_burst", rd, exp_status());

    // Reset mid-frame on both directions
    ahb_write(4'h0, 32'h5A);
    rxd = 1'b0;
    repeat (12) @(negedge hclk);
    check("midframe_busy", {30'd0, tx_busy, rx_busy}, 32'd3);
    hrst_n = 1'b0;
    #1;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {30'd0, tx_busy, rx_busy}, 32'd0);
    rxd = 1'b1;
    repeat (2) @(negedge hclk);
    hrst_n = 1'b1;
    ahb_read(4'h4, rd); check("status_post_reset", rd, 32'h0000_000A);
    ahb_read(4'h8, rd); check("baud_post_reset", rd, 32'h0000_0363);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
